// File: rtl/mbist_pkg.sv
// Shared encodings and helpers for the MBIST repair sequencer.
package mbist_pkg;

  localparam logic [1:0] MODE_TEST       = 2'b00;
  localparam logic [1:0] MODE_REPAIR     = 2'b01;
  localparam logic [1:0] MODE_VERIFY     = 2'b10;
  localparam logic [1:0] MODE_REPAIR_ALT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_P1_START,
    S_P1_RUN,
    S_EVAL,
    S_P2_START,
    S_P2_RUN,
    S_DONE
  } state_e;

  // Ceiling log2, never below 1 so a width derived from it is always legal.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Width of the per-pass timeout counter; it only has to reach t-1.
  function automatic int tmo_width(input int t);
    return clog2(t);
  endfunction

endpackage

// File: rtl/mbist_repair_sequencer_if.sv
// Handshake between the sequencer and the external March BIST engine.
interface mbist_repair_sequencer_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  bist_start;
  logic                  bist_done;
  logic                  bist_fail_valid;
  logic [ADDR_WIDTH-1:0] bist_fail_addr;

  modport master (
    output bist_start,
    input  bist_done,
    input  bist_fail_valid,
    input  bist_fail_addr
  );

  modport slave (
    input  bist_start,
    output bist_done,
    output bist_fail_valid,
    output bist_fail_addr
  );
endinterface

// File: rtl/repair_cam.sv
// Deduplicating repair table: logs failing addresses in insert order and
// remaps a functional address to its spare word by parallel compare.
module repair_cam
  import mbist_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int MAX_REPAIRS = 16,
  parameter int SPARE_BASE  = 240,
  localparam int CNT_W      = clog2(MAX_REPAIRS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  ins_req,
  input  logic [ADDR_WIDTH-1:0] ins_addr,
  output logic                  ins_dup,
  output logic                  ins_spare,
  output logic                  ins_full,
  input  logic                  remap_en,
  input  logic [ADDR_WIDTH-1:0] func_addr,
  output logic [ADDR_WIDTH-1:0] phys_addr,
  output logic                  remap_hit,
  output logic [CNT_W-1:0]      count
);

  localparam logic [ADDR_WIDTH-1:0] SPARE_BASE_A = ADDR_WIDTH'(SPARE_BASE);

  logic [ADDR_WIDTH-1:0] addr_q [MAX_REPAIRS];
  logic [ADDR_WIDTH-1:0] addr_d [MAX_REPAIRS];
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;
  logic                  ins_ok;

  // Entry i is valid exactly when i < count_q, so clearing is just count=0.
  always_comb begin
    ins_dup   = 1'b0;
    remap_hit = 1'b0;
    phys_addr = func_addr;
    for (int i = 0; i < MAX_REPAIRS; i++) begin
      if (CNT_W'(i) < count_q) begin
        if (addr_q[i] == ins_addr) ins_dup = 1'b1;
        if (remap_en && (addr_q[i] == func_addr)) begin
          remap_hit = 1'b1;
          phys_addr = SPARE_BASE_A + ADDR_WIDTH'(i);
        end
      end
    end
    ins_spare = (ins_addr >= SPARE_BASE_A);
    ins_full  = (count_q == CNT_W'(MAX_REPAIRS));
    ins_ok    = ins_req && !ins_dup && !ins_spare && !ins_full;
  end

  // Next-state for the table: clear on a new sequence, else append.
  always_comb begin
    count_d = count_q;
    addr_d  = addr_q;
    if (clr) begin
      count_d = '0;
    end else if (ins_ok) begin
      for (int i = 0; i < MAX_REPAIRS; i++) begin
        if (count_q == CNT_W'(i)) addr_d[i] = ins_addr;
      end
      count_d = count_q + CNT_W'(1);
    end
  end

  // Occupancy is control state and resets; stored addresses do not need to.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  // Address storage.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
  end

  assign count = count_q;

endmodule

// File: rtl/mbist_repair_sequencer.sv
// Repair-flow sequencer: runs a BIST pass, logs fails into the repair table,
// and in repair modes reruns the BIST with remap active as a verify pass.
module mbist_repair_sequencer
  import mbist_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int MEM_SIZE       = 256,
  parameter int MAX_REPAIRS    = 16,
  parameter int SPARE_BASE     = MEM_SIZE - MAX_REPAIRS,
  parameter int TIMEOUT_CYCLES = 16384,
  localparam int CNT_W         = clog2(MAX_REPAIRS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              mode,
  mbist_repair_sequencer_if.master bist,
  input  logic [ADDR_WIDTH-1:0]   func_addr,
  output logic [ADDR_WIDTH-1:0]   phys_addr,
  output logic                    remap_hit,
  output logic                    busy,
  output logic                    done,
  output logic                    fail,
  output logic                    overflow,
  output logic                    spare_fault,
  output logic                    timeout,
  output logic [CNT_W-1:0]        repair_count
);

  localparam int TMO_W = tmo_width(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             bist_start_q, bist_start_d;
  logic             fail_q, fail_d;
  logic             overflow_q, overflow_d;
  logic             spare_fault_q, spare_fault_d;
  logic             timeout_q, timeout_d;
  logic             p1_fail_q, p1_fail_d;
  logic             p2_fail_q, p2_fail_d;
  logic             cam_clr, cam_ins_req, cam_dup, cam_spare, cam_full;
  logic             remap_en;

  assign remap_en = (state_q == S_P2_RUN) || (state_q == S_DONE);

  repair_cam #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MAX_REPAIRS(MAX_REPAIRS),
    .SPARE_BASE (SPARE_BASE)
  ) u_cam (
    .clk      (clk),
    .rst      (rst),
    .clr      (cam_clr),
    .ins_req  (cam_ins_req),
    .ins_addr (bist.bist_fail_addr),
    .ins_dup  (cam_dup),
    .ins_spare(cam_spare),
    .ins_full (cam_full),
    .remap_en (remap_en),
    .func_addr(func_addr),
    .phys_addr(phys_addr),
    .remap_hit(remap_hit),
    .count    (repair_count)
  );

  // Next-state, flag updates and table control for the repair sequence.
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    tmo_cnt_d     = tmo_cnt_q;
    bist_start_d  = 1'b0;
    fail_d        = fail_q;
    overflow_d    = overflow_q;
    spare_fault_d = spare_fault_q;
    timeout_d     = timeout_q;
    p1_fail_d     = p1_fail_q;
    p2_fail_d     = p2_fail_q;
    cam_clr       = 1'b0;
    cam_ins_req   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mode_d        = mode;
          fail_d        = 1'b0;
          overflow_d    = 1'b0;
          spare_fault_d = 1'b0;
          timeout_d     = 1'b0;
          p1_fail_d     = 1'b0;
          p2_fail_d     = 1'b0;
          if (mode == MODE_VERIFY) begin
            state_d = S_P2_START;
          end else begin
            cam_clr = 1'b1;
            state_d = S_P1_START;
          end
        end
      end
      S_P1_START, S_P2_START: begin
        bist_start_d = 1'b1;
        tmo_cnt_d    = '0;
        state_d      = (state_q == S_P1_START) ? S_P1_RUN : S_P2_RUN;
      end
      S_P1_RUN: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        // A strobe is logged before a coincident done is acted on.
        if (bist.bist_fail_valid) begin
          p1_fail_d   = 1'b1;
          cam_ins_req = 1'b1;
          if (!cam_dup) begin
            if (cam_spare)     spare_fault_d = 1'b1;
            else if (cam_full) overflow_d    = 1'b1;
          end
        end
        if (bist.bist_done) begin
          if (mode_q == MODE_TEST) begin
            fail_d  = p1_fail_q | bist.bist_fail_valid;
            state_d = S_DONE;
          end else begin
            state_d = S_EVAL;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          timeout_d = 1'b1;
          fail_d    = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_EVAL: begin
        state_d = S_DONE;
        case (mode_q)
          MODE_REPAIR, MODE_REPAIR_ALT: begin
            if (!p1_fail_q) begin
              fail_d = 1'b0;
            end else if (overflow_q || spare_fault_q) begin
              fail_d = 1'b1;
            end else begin
              state_d = S_P2_START;
            end
          end
          default: fail_d = p1_fail_q;
        endcase
      end
      S_P2_RUN: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (bist.bist_fail_valid) p2_fail_d = 1'b1;
        if (bist.bist_done) begin
          fail_d  = p2_fail_q | bist.bist_fail_valid;
          state_d = S_DONE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          timeout_d = 1'b1;
          fail_d    = 1'b1;
          state_d   = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and flag registers; reset aborts any sequence in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      mode_q        <= MODE_TEST;
      tmo_cnt_q     <= '0;
      bist_start_q  <= 1'b0;
      fail_q        <= 1'b0;
      overflow_q    <= 1'b0;
      spare_fault_q <= 1'b0;
      timeout_q     <= 1'b0;
      p1_fail_q     <= 1'b0;
      p2_fail_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      tmo_cnt_q     <= tmo_cnt_d;
      bist_start_q  <= bist_start_d;
      fail_q        <= fail_d;
      overflow_q    <= overflow_d;
      spare_fault_q <= spare_fault_d;
      timeout_q     <= timeout_d;
      p1_fail_q     <= p1_fail_d;
      p2_fail_q     <= p2_fail_d;
    end
  end

  assign bist.bist_start = bist_start_q;
  assign busy            = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done            = (state_q == S_DONE);
  assign fail            = fail_q;
  assign overflow        = overflow_q;
  assign spare_fault     = spare_fault_q;
  assign timeout         = timeout_q;

endmodule

// File: tb/tb_mbist_repair_sequencer.sv
// Directed bench for the MBIST repair sequencer with a scripted BIST engine.
module tb_mbist_repair_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic [7:0] func_addr;
  logic [7:0] phys_addr;
  logic       remap_hit, busy, done, fail, overflow, spare_fault, timeout;
  logic [4:0] repair_count;

  int total = 0;
  int bad   = 0;
  int bs_cnt = 0;
  int bs_base;
  bit ok;
  int k;

  mbist_repair_sequencer_if #(.ADDR_WIDTH(8)) bus ();

  mbist_repair_sequencer #(
    .ADDR_WIDTH    (8),
    .MEM_SIZE      (256),
    .MAX_REPAIRS   (16),
    .SPARE_BASE    (240),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mode        (mode),
    .bist        (bus.master),
    .func_addr   (func_addr),
    .phys_addr   (phys_addr),
    .remap_hit   (remap_hit),
    .busy        (busy),
    .done        (done),
    .fail        (fail),
    .overflow    (overflow),
    .spare_fault (spare_fault),
    .timeout     (timeout),
    .repair_count(repair_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.bist_start) bs_cnt <= bs_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [1:0] m);
    start = 1'b1;
    mode  = m;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_bs(output bit got);
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.bist_start) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_done(output bit got);
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic strobe(input logic [7:0] a);
    bus.bist_fail_valid = 1'b1;
    bus.bist_fail_addr  = a;
    tick();
    bus.bist_fail_valid = 1'b0;
  endtask

  task automatic pass_done();
    bus.bist_done = 1'b1;
    tick();
    bus.bist_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'b00; func_addr = 8'h00;
    bus.bist_done = 1'b0; bus.bist_fail_valid = 1'b0; bus.bist_fail_addr = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_fail", 32'(fail), 0);
    chk("rst_bist_start", 32'(bus.bist_start), 0);
    chk("rst_count", 32'(repair_count), 0);
    chk("rst_flags", 32'({overflow, spare_fault, timeout, remap_hit}), 0);

    // Mode 01, clean pass, done 10 cycles after bist_start
    bs_base = bs_cnt;
    do_start(2'b01);
    chk("t1_busy", 32'(busy), 1);
    wait_bs(ok);
    chk("t1_bs_seen", 32'(ok), 1);
    repeat (9) tick();
    pass_done();
    chk("t1_eval_not_done", 32'(done), 0);
    tick();
    chk("t1_done", 32'(done), 1);
    chk("t1_fail", 32'(fail), 0);
    chk("t1_busy_low", 32'(busy), 0);
    chk("t1_count", 32'(repair_count), 0);
    repeat (3) tick();
    chk("t1_one_pass", 32'(bs_cnt - bs_base), 1);

    // Mode 01, fails 0x12, 0x12, 0x40 then clean verify
    bs_base = bs_cnt;
    do_start(2'b01);
    wait_bs(ok);
    chk("t2_bs1", 32'(ok), 1);
    strobe(8'h12);
    strobe(8'h12);
    strobe(8'h40);
    func_addr = 8'h12;
    tick();
    chk("t2_p1_no_remap", 32'({remap_hit, phys_addr}), 32'h012);
    chk("t2_count", 32'(repair_count), 2);
    pass_done();
    wait_bs(ok);
    chk("t2_bs2", 32'(ok), 1);
    chk("t2_p2_remap", 32'({remap_hit, phys_addr}), 32'h1F0);
    repeat (4) tick();
    pass_done();
    wait_done(ok);
    chk("t2_done", 32'(ok), 1);
    chk("t2_fail", 32'(fail), 0);
    chk("t2_two_passes", 32'(bs_cnt - bs_base), 2);
    func_addr = 8'h40;
    #1;
    chk("t2_remap_40", 32'({remap_hit, phys_addr}), 32'h1F1);
    func_addr = 8'h41;
    #1;
    chk("t2_miss_41", 32'({remap_hit, phys_addr}), 32'h041);

    // Mode 01, 17 unique fails overflow the table
    bs_base = bs_cnt;
    do_start(2'b01);
    wait_bs(ok);
    for (int i = 0; i < 17; i++) strobe(8'(i));
    chk("t3_count", 32'(repair_count), 16);
    chk("t3_overflow", 32'(overflow), 1);
    pass_done();
    wait_done(ok);
    chk("t3_done", 32'(ok), 1);
    chk("t3_fail", 32'(fail), 1);
    repeat (3) tick();
    chk("t3_no_p2", 32'(bs_cnt - bs_base), 1);

    // Mode 01, fail in spare region
    do_start(2'b01);
    chk("t4_cleared", 32'({overflow, done}), 0);
    wait_bs(ok);
    strobe(8'hF3);
    pass_done();
    wait_done(ok);
    chk("t4_spare_fault", 32'(spare_fault), 1);
    chk("t4_count", 32'(repair_count), 0);
    chk("t4_fail", 32'(fail), 1);

    // Mode 00, fail coincident with done: logged, single pass, 1-cycle done
    bs_base = bs_cnt;
    do_start(2'b00);
    wait_bs(ok);
    bus.bist_fail_valid = 1'b1;
    bus.bist_fail_addr  = 8'h05;
    bus.bist_done       = 1'b1;
    tick();
    bus.bist_fail_valid = 1'b0;
    bus.bist_done       = 1'b0;
    chk("t5_done_1cyc", 32'(done), 1);
    chk("t5_fail", 32'(fail), 1);
    chk("t5_count", 32'(repair_count), 1);
    repeat (3) tick();
    chk("t5_one_pass", 32'(bs_cnt - bs_base), 1);

    // Mode 01, bist_done never comes
    do_start(2'b01);
    wait_bs(ok);
    k = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (done) begin
        k = i;
        break;
      end
    end
    chk("t6_timeout_cycles", 32'(k), 64);
    chk("t6_timeout", 32'(timeout), 1);
    chk("t6_fail", 32'(fail), 1);

    // Reset during P2_RUN, then mode 10 with the now-empty table
    do_start(2'b01);
    wait_bs(ok);
    strobe(8'h12);
    pass_done();
    wait_bs(ok);
    chk("t7_in_p2", 32'(ok), 1);
    repeat (5) tick();
    func_addr = 8'h12;
    rst = 1'b1;
    tick();
    chk("t7_rst_outs", 32'({busy, done, fail, overflow, spare_fault, timeout, remap_hit, bus.bist_start}), 0);
    chk("t7_rst_count", 32'(repair_count), 0);
    chk("t7_rst_phys", 32'(phys_addr), 32'h12);
    rst = 1'b0;
    bs_base = bs_cnt;
    repeat (4) tick();
    chk("t7_no_bs_after_rst", 32'(bs_cnt - bs_base), 0);
    do_start(2'b10);
    wait_bs(ok);
    chk("t7_verify_bs", 32'(ok), 1);
    for (int i = 0; i < 4; i++) begin
      func_addr = 8'(i * 85);
      tick();
      chk("t7_no_hit", 32'({remap_hit, phys_addr}), 32'(i * 85));
    end
    pass_done();
    chk("t7_done_1cyc", 32'(done), 1);
    chk("t7_fail", 32'(fail), 0);
    chk("t7_one_pass", 32'(bs_cnt - bs_base), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
